imem_boot_loader: RTL
=====================

IMEM_BOOT_LOADER -- requirements
Module: imem_boot_loader

Interface
REQ-001 Parameter MEM_BYTES, default 1024, instruction memory capacity in bytes.
REQ-002 Parameter TIMEOUT_CYCLES, default 4096, maximum consecutive LOAD cycles without in_valid before abort.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle pulse requesting a program load.
REQ-006 byte_len  input  16  number of program bytes to load, sampled on accepted start.
REQ-007 in_valid  input  1  byte stream valid.
REQ-008 in_data  input  8  byte stream data, program order (instruction MSB first).
REQ-009 in_ready  output  1  loader accepts a byte this cycle.
REQ-010 mem_we  output  1  one-cycle word write strobe to instruction memory.
REQ-011 mem_addr  output  32  word-aligned byte address of the write.
REQ-012 mem_wdata  output  32  word; bits 31:24 go to mem_addr, bits 7:0 to mem_addr+3.
REQ-013 cpu_rst  output  1  holds the pipeline in reset while high.
REQ-014 busy, done, error  output  1 each  status flags.

Function
REQ-015 States IDLE, LOAD, FLUSH, DONE, ERR; busy=1 exactly in LOAD and FLUSH.
REQ-016 IDLE/DONE/ERR + start: byte_len==0 -> DONE; byte_len>MEM_BYTES -> ERR; else LOAD, word address and byte counter cleared.
REQ-017 start while busy is ignored.
REQ-018 LOAD: in_ready=1; a byte is accepted when in_valid&&in_ready; throughput one byte per cycle.
REQ-019 Every 4th accepted byte completes a word: mem_we=1 for exactly one cycle on the following cycle, mem_addr=4*word_index, mem_wdata={b0,b1,b2,b3}; in_ready stays high during the write.
REQ-020 After byte_len bytes accepted with byte_len%4!=0 -> FLUSH: remaining bytes padded 0x00 (NOP), one word written, in_ready=0.
REQ-021 Final word written -> DONE next cycle; DONE: done=1, cpu_rst=0, in_ready=0.
REQ-022 cpu_rst=1 in every state except DONE; a new start from DONE reasserts cpu_rst the next cycle.
REQ-023 Bytes beyond byte_len are not accepted (in_ready=0 once byte_len reached).
REQ-024 Timeout counter resets on each accepted byte; reaching TIMEOUT_CYCLES in LOAD -> ERR, no further mem_we.
REQ-025 ERR: error=1, cpu_rst=1, in_ready=0; left only by start or rst.
REQ-026 mem_addr never exceeds MEM_BYTES-4.

Reset
REQ-027 rst asserted: state IDLE; in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst=1, busy=0, done=0, error=0.
REQ-028 rst mid-load aborts immediately with no partial-word write; memory contents unspecified.

Configuration
REQ-029 With IMEM_LOADER_CHECKSUM_EN defined: after byte_len bytes (before FLUSH/DONE), one extra checksum byte is accepted; if it differs from the XOR of all program bytes -> ERR, already written words remain.
REQ-030 Without IMEM_LOADER_CHECKSUM_EN: no checksum byte consumed, no mismatch path to ERR.

Structure
REQ-031 State encodings, MEM_BYTES default and TIMEOUT_CYCLES default live in defines.v beside WORD_LEN and INSTR_MEM_SIZE.
REQ-032 One sub-module, imem_word_packer: shifts bytes in MSB first, flags word complete, supports zero padding.

Verification
REQ-033 start, byte_len=8, bytes 80 20 00 0A 04 40 08 00 back-to-back -> writes (0x0,0x8020000A),(0x4,0x04400800); done=1, cpu_rst=0 one cycle after last write.
REQ-034 byte_len=6, bytes 11 22 33 44 55 66 -> writes (0x0,0x11223344),(0x4,0x55660000).
REQ-035 byte_len=4, in_valid low 4096 cycles after first byte -> error=1, cpu_rst=1, no mem_we.
REQ-036 byte_len=2000 -> ERR next cycle, in_ready never high.
REQ-037 rst pulsed after 3 of 8 bytes -> no mem_we, all outputs at reset values; new start loads correctly.
REQ-038 With IMEM_LOADER_CHECKSUM_EN: byte_len=4, bytes 01 02 04 08 then 0x0F -> DONE; then 0x0E -> ERR after the word write.

Source files
------------

// File: rtl/imem_boot_loader_pkg.sv
// Shared constants for the instruction-memory boot loader: word geometry, defaults, FSM encodings.
// Also holds the zero-padding helper used when a program ends mid-word.
package imem_boot_loader_pkg;

    localparam int WORD_LEN            = 32;
    localparam int INSTR_MEM_SIZE      = 1024;
    localparam int MEM_BYTES_DFLT      = INSTR_MEM_SIZE;
    localparam int TIMEOUT_CYCLES_DFLT = 4096;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_FLUSH = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

    // Left-justify the partial bytes held so far; missing low bytes become 0x00 (NOP).
    function automatic logic [WORD_LEN-1:0] pad_word(input logic [23:0] acc, input logic [1:0] cnt);
        logic [WORD_LEN-1:0] w;
        w = '0;
        case (cnt)
            2'd1:    w = {acc[7:0], 24'h0};
            2'd2:    w = {acc[15:0], 16'h0};
            2'd3:    w = {acc, 8'h0};
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Packs a byte stream MSB-first into 32-bit words; flags the byte that completes a word.
// Latency: word_dat is combinational with the completing byte. No backpressure (caller gates shift_en).
// Zero-padded partial word is always available on pad_dat.
module imem_word_packer
    import imem_boot_loader_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                shift_en,
    input  logic [7:0]          shift_dat,
    output logic [1:0]          fill_cnt,
    output logic                word_full,
    output logic [WORD_LEN-1:0] word_dat,
    output logic [WORD_LEN-1:0] pad_dat
);

    logic [23:0] acc_q, acc_d;
    logic [1:0]  cnt_q, cnt_d;

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clr) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (shift_en) begin
            acc_d = {acc_q[15:0], shift_dat};
            cnt_d = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign fill_cnt  = cnt_q;
    assign word_full = shift_en && !clr && (cnt_q == 2'd3);
    assign word_dat  = {acc_q, shift_dat};
    assign pad_dat   = pad_word(acc_q, cnt_q);

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a program byte-wise into instruction memory as word writes, holding the CPU in reset until done.
// Latency: word write one cycle after its 4th byte; done one cycle after the final write.
// Backpressure: in_ready only in LOAD while bytes remain. IMEM_LOADER_CHECKSUM_EN adds a trailing XOR byte.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int MEM_BYTES      = MEM_BYTES_DFLT,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DFLT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] byte_len,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

    logic [2:0]  state_q, state_d;
    logic [15:0] byte_len_q, byte_len_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;
    logic [31:0] word_addr_q, word_addr_d;
    logic [31:0] to_cnt_q, to_cnt_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic        data_phase, load_fin, cks_fail, accept, pk_shift, pk_clr, pk_full;
    logic [1:0]  pk_cnt;
    logic [31:0] pk_word, pk_pad;

    assign data_phase = (byte_cnt_q != byte_len_q);

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] xor_q, xor_d;
    logic       cks_got_q, cks_got_d;
    logic       cks_bad_q, cks_bad_d;

    assign in_ready = (state_q == ST_LOAD) && (data_phase || !cks_got_q);
    assign load_fin = !data_phase && cks_got_q;
    assign cks_fail = cks_bad_q;
`else
    assign in_ready = (state_q == ST_LOAD) && data_phase;
    assign load_fin = !data_phase;
    assign cks_fail = 1'b0;
`endif

    assign accept   = in_valid && in_ready;
    assign pk_shift = accept && data_phase;

    imem_word_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (pk_clr),
        .shift_en  (pk_shift),
        .shift_dat (in_data),
        .fill_cnt  (pk_cnt),
        .word_full (pk_full),
        .word_dat  (pk_word),
        .pad_dat   (pk_pad)
    );

    always_comb begin
        state_d     = state_q;
        byte_len_d  = byte_len_q;
        byte_cnt_d  = byte_cnt_q;
        word_addr_d = word_addr_q;
        to_cnt_d    = to_cnt_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        pk_clr      = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_d     = xor_q;
        cks_got_d = cks_got_q;
        cks_bad_d = cks_bad_q;
`endif
        case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    to_cnt_d = '0;
                    if (data_phase) begin
                        byte_cnt_d = byte_cnt_q + 16'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xor_d = xor_q ^ in_data;
`endif
                        if (pk_full) begin
                            mem_we_d    = 1'b1;
                            mem_addr_d  = word_addr_q;
                            mem_wdata_d = pk_word;
                            word_addr_d = word_addr_q + 32'd4;
                        end
                    end
`ifdef IMEM_LOADER_CHECKSUM_EN
                    else begin
                        cks_got_d = 1'b1;
                        cks_bad_d = (in_data != xor_q);
                    end
`endif
                end else if (load_fin) begin
                    // A full-word tail is already being written this cycle, so DONE lands right after it.
                    if (cks_fail)
                        state_d = ST_ERR;
                    else if (pk_cnt != 2'd0)
                        state_d = ST_FLUSH;
                    else
                        state_d = ST_DONE;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d = ST_ERR;
                end else begin
                    to_cnt_d = to_cnt_q + 32'd1;
                end
            end
            ST_FLUSH: begin
                if (mem_we_q) begin
                    state_d = ST_DONE;
                end else begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = word_addr_q;
                    mem_wdata_d = pk_pad;
                    word_addr_d = word_addr_q + 32'd4;
                    pk_clr      = 1'b1;
                end
            end
            default: begin
                if (start) begin
                    byte_len_d  = byte_len;
                    byte_cnt_d  = '0;
                    word_addr_d = '0;
                    to_cnt_d    = '0;
                    pk_clr      = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_d     = '0;
                    cks_got_d = 1'b0;
                    cks_bad_d = 1'b0;
`endif
                    if (byte_len == 16'd0)
                        state_d = ST_DONE;
                    else if (32'(byte_len) > MEM_LIMIT)
                        state_d = ST_ERR;
                    else
                        state_d = ST_LOAD;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            byte_len_q  <= '0;
            byte_cnt_q  <= '0;
            word_addr_q <= '0;
            to_cnt_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            byte_len_q  <= byte_len_d;
            byte_cnt_q  <= byte_cnt_d;
            word_addr_q <= word_addr_d;
            to_cnt_q    <= to_cnt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xor_q     <= '0;
            cks_got_q <= 1'b0;
            cks_bad_q <= 1'b0;
        end else begin
            xor_q     <= xor_d;
            cks_got_q <= cks_got_d;
            cks_bad_q <= cks_bad_d;
        end
    end
`endif

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q == ST_LOAD) || (state_q == ST_FLUSH);
    assign done      = (state_q == ST_DONE);
    assign error     = (state_q == ST_ERR);
    assign cpu_rst   = (state_q != ST_DONE);

endmodule
